// File: rtl/uart_msg_sequencer.sv
// Sends a fixed MSG_LEN-byte message to a UART transmitter one byte at a time,
// paced by Tx_BUSY, with an inter-byte gap, ack timeout and optional looping.
module uart_msg_sequencer #(
    parameter int          MSG_LEN     = 4,
    parameter logic [63:0] MSG_DATA    = 64'hAA55CC89_00000000,
    parameter int          GAP_CYCLES  = 16,
    parameter int          ACK_TIMEOUT = 1024
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       start,
    input  logic       loop_en,
    input  logic       Tx_BUSY,
    output logic       Tx_EN,
    output logic       Tx_WR,
    output logic [7:0] Tx_DATA,
    output logic       seq_busy,
    output logic       seq_done,
    output logic       seq_error,
    output logic [2:0] byte_idx
);

    localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [2:0]       IDX_LAST = 3'(MSG_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        WAIT_ACK,
        WAIT_DONE,
        GAP,
        DONE,
        ERROR
    } state_t;

    state_t           state_reg, state_next;
    logic [2:0]       byte_idx_reg, byte_idx_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       msg_bytes [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_msg_bytes
            assign msg_bytes[gi] = MSG_DATA[63-8*gi -: 8];
        end
    endgenerate

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            byte_idx_reg <= '0;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            byte_idx_reg <= byte_idx_next;
            cnt_reg      <= cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        byte_idx_next = byte_idx_reg;
        cnt_next      = cnt_reg;

        // Outputs decode straight from the state register so an async reset
        // drops them in the same cycle.
        Tx_EN     = 1'b0;
        Tx_WR     = 1'b0;
        Tx_DATA   = msg_bytes[byte_idx_reg];
        seq_busy  = 1'b0;
        seq_done  = 1'b0;
        seq_error = 1'b0;
        byte_idx  = byte_idx_reg;

        case (state_reg)
            IDLE: begin
                Tx_DATA  = 8'h00;
                cnt_next = '0;
                if (start) begin
                    state_next    = LOAD;
                    byte_idx_next = '0;
                end
            end
            LOAD: begin
                Tx_EN    = 1'b1;
                seq_busy = 1'b1;
                if (!Tx_BUSY) begin
                    state_next = WRITE;
                    cnt_next   = '0;
                end
            end
            WRITE: begin
                // The ack timeout starts counting on the write cycle itself.
                Tx_EN      = 1'b1;
                Tx_WR      = 1'b1;
                seq_busy   = 1'b1;
                cnt_next   = cnt_reg + 1'b1;
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                Tx_EN    = 1'b1;
                seq_busy = 1'b1;
                if (Tx_BUSY) begin
                    state_next = WAIT_DONE;
                end else if (cnt_reg >= ACK_LAST) begin
                    state_next = ERROR;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            WAIT_DONE: begin
                Tx_EN    = 1'b1;
                seq_busy = 1'b1;
                if (!Tx_BUSY) begin
                    state_next = GAP;
                    cnt_next   = '0;
                end
            end
            GAP: begin
                Tx_EN    = 1'b1;
                seq_busy = 1'b1;
                if (cnt_reg == GAP_LAST) begin
                    if (byte_idx_reg == IDX_LAST) begin
                        state_next = DONE;
                    end else begin
                        state_next    = LOAD;
                        byte_idx_next = byte_idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                seq_done = 1'b1;
                if (loop_en) begin
                    state_next    = LOAD;
                    byte_idx_next = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            ERROR: begin
                Tx_DATA   = 8'h00;
                seq_error = 1'b1;
                cnt_next  = '0;
                if (start) begin
                    state_next    = LOAD;
                    byte_idx_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Directed bench for uart_msg_sequencer with a simple transmitter stand-in
// that goes busy for a fixed frame length after each write.
module tb_uart_msg_sequencer;

    localparam int ACK_TIMEOUT = 1024;
    localparam int FRAME_CYC   = 10;

    logic       Clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       start   = 1'b0;
    logic       loop_en = 1'b0;
    logic       Tx_BUSY;
    logic       Tx_EN, Tx_WR, seq_busy, seq_done, seq_error;
    logic [7:0] Tx_DATA;
    logic [2:0] byte_idx;

    logic       model_en    = 1'b1;
    logic       forced_busy = 1'b0;
    int         model_cnt   = 0;
    logic [7:0] rx_q [$];

    int   cyc      = 0;
    int   wr_total = 0;
    int   b2b      = 0;
    logic prev_wr  = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_bytes [4] = '{8'hAA, 8'h55, 8'hCC, 8'h89};

    uart_msg_sequencer #(
        .MSG_LEN    (4),
        .MSG_DATA   (64'hAA55CC89_00000000),
        .GAP_CYCLES (16),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .Clk      (Clk),
        .reset    (reset),
        .start    (start),
        .loop_en  (loop_en),
        .Tx_BUSY  (Tx_BUSY),
        .Tx_EN    (Tx_EN),
        .Tx_WR    (Tx_WR),
        .Tx_DATA  (Tx_DATA),
        .seq_busy (seq_busy),
        .seq_done (seq_done),
        .seq_error(seq_error),
        .byte_idx (byte_idx)
    );

    always #5 Clk = ~Clk;

    assign Tx_BUSY = (model_en && (model_cnt != 0)) || forced_busy;

    // Transmitter stand-in: captures the byte on the write strobe, then busy.
    always @(posedge Clk or posedge reset) begin
        if (reset) begin
            model_cnt <= 0;
        end else if (model_en && Tx_WR) begin
            model_cnt <= FRAME_CYC;
            rx_q.push_back(Tx_DATA);
        end else if (model_cnt != 0) begin
            model_cnt <= model_cnt - 1;
        end
    end

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (Tx_WR) wr_total <= wr_total + 1;
        if (Tx_WR && prev_wr) b2b <= b2b + 1;
        prev_wr <= Tx_WR;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
    endtask

    initial begin
        int  rx_base, wr_base, done_cnt, wr_cyc, err_cyc;
        bit  found;

        // Reset state
        tick(2);
        check("reset_outputs", 32'({Tx_EN, Tx_WR, Tx_DATA, seq_busy, seq_done, seq_error, byte_idx}), 32'd0);
        reset = 1'b0;
        tick(1);

        // Start latency: LOAD next cycle, write strobe two cycles after start
        rx_base = rx_q.size();
        wr_base = wr_total;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("t1_load_en", 32'(Tx_EN), 32'd1);
        check("t1_load_no_wr", 32'(Tx_WR), 32'd0);
        tick(1);
        check("t1_wr", 32'(Tx_WR), 32'd1);
        check("t1_wr_data", 32'(Tx_DATA), 32'hAA);
        check("t1_wr_en", 32'(Tx_EN), 32'd1);
        $display("T1 start latency: Tx_WR=%0b Tx_DATA=%02h", Tx_WR, Tx_DATA);

        // Full message through the transmitter stand-in
        done_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            tick(1);
            if (seq_done) done_cnt++;
        end
        check("t2_done_pulses", 32'(done_cnt), 32'd1);
        check("t2_wr_total", 32'(wr_total - wr_base), 32'd4);
        check("t2_rx_count", 32'(rx_q.size() - rx_base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_byte%0d", k), 32'(rx_q[rx_base+k]), 32'(exp_bytes[k]));
        end
        check("t2_idle_busy", 32'(seq_busy), 32'd0);
        $display("T2 message: writes=%0d done_pulses=%0d", wr_total - wr_base, done_cnt);

        // Ack timeout with Tx_BUSY tied low
        pulse_reset();
        model_en = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        found  = 1'b0;
        wr_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            if (Tx_WR) begin
                found  = 1'b1;
                wr_cyc = cyc;
                break;
            end
            tick(1);
        end
        check("t3_wr_seen", 32'(found), 32'd1);
        found   = 1'b0;
        err_cyc = 0;
        for (int i = 0; i < ACK_TIMEOUT + 50; i++) begin
            tick(1);
            if (seq_error) begin
                found   = 1'b1;
                err_cyc = cyc;
                break;
            end
        end
        check("t3_error_seen", 32'(found), 32'd1);
        check("t3_error_delay", 32'(err_cyc - wr_cyc), 32'(ACK_TIMEOUT));
        check("t3_error_en", 32'(Tx_EN), 32'd0);
        check("t3_error_data", 32'(Tx_DATA), 32'd0);
        check("t3_error_busy", 32'(seq_busy), 32'd0);
        tick(5);
        check("t3_error_sticky", 32'(seq_error), 32'd1);
        check("t3_error_no_wr", 32'(Tx_WR), 32'd0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("t3_error_cleared", 32'(seq_error), 32'd0);
        check("t3_restart_en", 32'(Tx_EN), 32'd1);
        tick(1);
        check("t3_restart_wr", 32'(Tx_WR), 32'd1);
        check("t3_restart_data", 32'(Tx_DATA), 32'hAA);
        $display("T3 timeout: delay=%0d cycles", err_cyc - wr_cyc);

        // Busy transmitter at start holds the sequencer in LOAD
        pulse_reset();
        model_en    = 1'b1;
        forced_busy = 1'b1;
        wr_base     = wr_total;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(20);
        check("t4_hold_en", 32'(Tx_EN), 32'd1);
        check("t4_hold_busy", 32'(seq_busy), 32'd1);
        check("t4_hold_no_wr", 32'(wr_total - wr_base), 32'd0);
        check("t4_hold_data", 32'(Tx_DATA), 32'hAA);
        forced_busy = 1'b0;
        tick(1);
        check("t4_release_wr", 32'(Tx_WR), 32'd1);
        $display("T4 busy hold: Tx_WR after release=%0b", Tx_WR);

        // Looping message; start toggled mid-message must be ignored
        pulse_reset();
        loop_en = 1'b1;
        wr_base = wr_total;
        rx_base = rx_q.size();
        start = 1'b1;
        tick(1);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            start = ((i % 7) < 3);
            tick(1);
            if (seq_done) begin
                found = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check("t5_done_seen", 32'(found), 32'd1);
        check("t5_wr_count", 32'(wr_total - wr_base), 32'd4);
        check("t5_done_idx", 32'(byte_idx), 32'd3);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t5_byte%0d", k), 32'(rx_q[rx_base+k]), 32'(exp_bytes[k]));
        end
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (Tx_WR) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_loop_wr", 32'(found), 32'd1);
        check("t5_loop_data", 32'(Tx_DATA), 32'hAA);
        check("t5_loop_idx", 32'(byte_idx), 32'd0);
        loop_en = 1'b0;
        $display("T5 loop: restart Tx_DATA=%02h byte_idx=%0d", Tx_DATA, byte_idx);

        // Async reset during WAIT_DONE of byte 2
        pulse_reset();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (Tx_WR && byte_idx == 3'd2) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_byte2_wr", 32'(found), 32'd1);
        tick(3);
        check("t6_pre_busy", 32'(seq_busy), 32'd1);
        check("t6_pre_txbusy", 32'(Tx_BUSY), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("t6_reset_outputs", 32'({Tx_EN, Tx_WR, Tx_DATA, seq_busy, seq_done, seq_error, byte_idx}), 32'd0);
        tick(1);
        reset = 1'b0;
        tick(3);
        check("t6_stays_idle", 32'({Tx_EN, seq_busy}), 32'd0);
        $display("T6 mid-byte reset: Tx_EN=%0b seq_busy=%0b", Tx_EN, seq_busy);

        check("no_back_to_back_wr", 32'(b2b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
